// File: rtl/bist_response_analyzer_pkg.sv
// rtl/bist_response_analyzer_pkg.sv - shared BIST types, default constants and MISR step
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_COMPACT = 2'd2,
        ST_CHECK   = 2'd3
    } bist_state_t;

    localparam logic [7:0] DEFAULT_POLY = 8'h1D;
    localparam logic [7:0] DEFAULT_SEED = 8'h00;
    localparam int         MISR_MAX_W   = 64;

    // Width-generic MISR step; callers zero-extend into MISR_MAX_W and truncate the result.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] din,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [MISR_MAX_W-1:0] fb;
        logic [MISR_MAX_W-1:0] mask;
        fb   = (((sig >> (width - 1)) & MISR_MAX_W'(1)) != '0) ? poly : '0;
        mask = (MISR_MAX_W'(1) << width) - MISR_MAX_W'(1);
        return ((sig << 1) ^ fb ^ din) & mask;
    endfunction

endpackage

// File: rtl/bist_response_analyzer_if.sv
// rtl/bist_response_analyzer_if.sv - controller strobes, CUT bus and verdict outputs
interface bist_response_analyzer_if #(
    parameter int WIDTH = 8
);
    logic             init;
    logic             running;
    logic             toggle;
    logic             finish;
    logic [WIDTH-1:0] cut_out;
    logic [WIDTH-1:0] signature;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             proto_err;

    modport master (
        output init, running, toggle, finish, cut_out,
        input  signature, busy, done, pass, fail, proto_err
    );

    modport slave (
        input  init, running, toggle, finish, cut_out,
        output signature, busy, done, pass, fail, proto_err
    );
endinterface

// File: rtl/bist_response_analyzer_misr.sv
// rtl/bist_response_analyzer_misr.sv - WIDTH-bit MISR register with seed load
module bist_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (en) begin
            q_d = WIDTH'(misr_step(MISR_MAX_W'(q_q), MISR_MAX_W'(din),
                                   MISR_MAX_W'(POLY), WIDTH));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= SEED;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - MISR compaction, run-length/protocol checks and verdict
// Optional toggle-alternation check enabled by BIST_TOGGLE_CHECK_EN.
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               NRUN   = 11,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEFAULT_SEED),
    parameter logic [WIDTH-1:0] GOLDEN = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    bist_response_analyzer_if.slave      bus
);
    localparam int CW = $clog2(NRUN + 2);

    bist_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             proto_q, proto_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             load, en, tgl_err;
    logic [WIDTH-1:0] sig_q, sig_step, sig_fin;

`ifdef BIST_TOGGLE_CHECK_EN
    logic tgl_q, tgl_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tgl_q <= 1'b0;
        else       tgl_q <= tgl_d;
    end

    assign tgl_d   = en ? bus.toggle : tgl_q;
    // Only running cycles already in COMPACT have a predecessor to compare against.
    assign tgl_err = (state_q == ST_COMPACT) && bus.running && (bus.toggle == tgl_q);
`else
    assign tgl_err = 1'b0;
`endif

    bist_misr #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .seed  (SEED),
        .en    (en),
        .din   (bus.cut_out),
        .q     (sig_q)
    );

    assign sig_step = WIDTH'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(bus.cut_out),
                                       MISR_MAX_W'(POLY), WIDTH));
    assign cnt_inc  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            proto_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            proto_q <= proto_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        proto_d = proto_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        load    = 1'b0;
        en      = 1'b0;
        sig_fin = sig_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.init) begin
                    state_d = ST_ARMED;
                    load    = 1'b1;
                    cnt_d   = '0;
                    proto_d = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            ST_ARMED: begin
                if (bus.running) begin
                    en      = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = bus.finish ? ST_CHECK : ST_COMPACT;
                end else if (bus.finish) begin
                    proto_d = 1'b1;
                    state_d = ST_CHECK;
                end else if (bus.init) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    proto_d = 1'b0;
                end
            end
            ST_COMPACT: begin
                if (bus.finish) begin
                    en      = bus.running;
                    cnt_d   = bus.running ? cnt_inc : cnt_q;
                    proto_d = proto_q | tgl_err;
                    state_d = ST_CHECK;
                end else if (bus.init) begin
                    proto_d = 1'b1;
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_ARMED;
                end else if (bus.running) begin
                    en      = 1'b1;
                    cnt_d   = cnt_inc;
                    proto_d = proto_q | tgl_err;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (en) sig_fin = sig_step;
        if ((state_d == ST_CHECK) && (state_q != ST_CHECK)) begin
            pass_d = (sig_fin == GOLDEN) && (cnt_d == CW'(NRUN)) && !proto_d;
            fail_d = !pass_d;
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            ST_ARMED, ST_COMPACT: bus.busy = 1'b1;
            ST_CHECK:             bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.signature = sig_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.proto_err = proto_q;
endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed and randomized checks against a signature model
module tb_bist_response_analyzer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bist_response_analyzer_if #(.WIDTH(8)) bus ();

    bist_response_analyzer #(.WIDTH(8), .NRUN(11), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One MISR compaction step in plain arithmetic.
    function automatic int model_step(input int s, input int d);
        return ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0) ^ d;
    endfunction

    task automatic cyc(input logic i, input logic r, input logic t, input logic f, input logic [7:0] d);
        bus.init    = i;
        bus.running = r;
        bus.toggle  = t;
        bus.finish  = f;
        bus.cut_out = d;
        @(posedge clk);
        #1;
        bus.init    = 1'b0;
        bus.running = 1'b0;
        bus.finish  = 1'b0;
        bus.cut_out = 8'h00;
    endtask

    // mode 0: zeros (optional single fault), 1: random, 2: random with last byte zeroing the signature
    task automatic do_test(input string tag, input int n, input int mode, input int fault_at, input int tog_dup_at);
        int s;
        int d;
        int cntm;
        bit tog;
        bit exp_proto;
        bit exp_pass;
        s   = 0;
        tog = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk({tag, "_armed_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (mode != 0 && $urandom_range(0, 3) == 0) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'(($urandom_range(0, 255))));
                chk({tag, "_gap_sig"}, 32'(bus.signature), 32'(s));
            end
            d = (mode == 0) ? ((k == fault_at) ? 1 : 0) : int'($urandom_range(0, 255));
            if (mode == 2 && k == n - 1) d = model_step(s, 0);
            if (k > 0 && k != tog_dup_at) tog = ~tog;
            s = model_step(s, d);
            cyc(1'b0, 1'b1, tog, 1'b0, 8'(d));
            chk({tag, "_sig"}, 32'(bus.signature), 32'(s));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        exp_proto = (n == 0);
`ifdef BIST_TOGGLE_CHECK_EN
        if (tog_dup_at > 0 && tog_dup_at < n) exp_proto = 1'b1;
`endif
        cntm     = (n > 15) ? 15 : n;
        exp_pass = (s == 0) && (cntm == 11) && !exp_proto;
        chk({tag, "_done"},  32'(bus.done),      32'd1);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_pass"},  32'(bus.pass),      32'(exp_pass));
        chk({tag, "_fail"},  32'(bus.fail),      32'(!exp_pass));
        chk({tag, "_proto"}, 32'(bus.proto_err), 32'(exp_proto));
        chk({tag, "_final"}, 32'(bus.signature), 32'(s));
        // init during CHECK must be ignored
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"},      32'(bus.busy), 32'd0);
        chk({tag, "_sticky"},    32'(bus.pass), 32'(exp_pass));
    endtask

    initial begin
        bit tog;
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        bus.init    = 1'b0;
        bus.running = 1'b0;
        bus.toggle  = 1'b0;
        bus.finish  = 1'b0;
        bus.cut_out = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig",   32'(bus.signature), 32'h00);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_done",  32'(bus.done),      32'd0);
        chk("rst_pass",  32'(bus.pass),      32'd0);
        chk("rst_fail",  32'(bus.fail),      32'd0);
        chk("rst_proto", 32'(bus.proto_err), 32'd0);
        reset = 1'b0;

        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
        chk("idle_ignore_busy", 32'(bus.busy), 32'd0);
        chk("idle_ignore_done", 32'(bus.done), 32'd0);
        chk("idle_ignore_sig",  32'(bus.signature), 32'h00);

        do_test("zero_pass",  11, 0, -1, -1);
        do_test("fault5",     11, 0,  4, -1);
        do_test("len10",      10, 0, -1, -1);
        do_test("len12",      12, 0, -1, -1);
        do_test("len17",      17, 0, -1, -1);
        do_test("no_run",      0, 0, -1, -1);
        for (int i = 0; i < 4; i++) do_test("rand", 11, 1, -1, -1);
        for (int i = 0; i < 4; i++) do_test("rand_zero", 11, 2, -1, -1);
        do_test("rand_len9",   9, 2, -1, -1);
        do_test("toggle_dup", 11, 0, -1, 3);

        // init during COMPACT: proto_err, reseed, back to ARMED, count restarts
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tog = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, tog, 1'b0, 8'h81);
            tog = ~tog;
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reinit_proto", 32'(bus.proto_err), 32'd1);
        chk("reinit_busy",  32'(bus.busy),      32'd1);
        chk("reinit_sig",   32'(bus.signature), 32'h00);
        tog = 1'b1;
        for (int k = 0; k < 11; k++) begin
            cyc(1'b0, 1'b1, tog, 1'b0, 8'h00);
            tog = ~tog;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("reinit_done",  32'(bus.done),      32'd1);
        chk("reinit_fail",  32'(bus.fail),      32'd1);
        chk("reinit_pass",  32'(bus.pass),      32'd0);
        chk("reinit_sig0",  32'(bus.signature), 32'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // reset asserted during run cycle 6
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tog = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, tog, 1'b0, 8'hA5);
            tog = ~tog;
        end
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        bus.running = 1'b1;
        bus.toggle  = tog;
        bus.cut_out = 8'h3C;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sig",   32'(bus.signature), 32'h00);
        chk("arst_busy",  32'(bus.busy),      32'd0);
        chk("arst_done",  32'(bus.done),      32'd0);
        chk("arst_pass",  32'(bus.pass),      32'd0);
        chk("arst_fail",  32'(bus.fail),      32'd0);
        chk("arst_proto", 32'(bus.proto_err), 32'd0);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.running = 1'b0;
        bus.cut_out = 8'h00;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("arst_no_done", 32'(bus.done), 32'd0);
        do_test("after_rst", 11, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
